// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU operations, control bundle and reset images
// for the single-cycle MIPS datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst_rd;
        logic    alu_src_imm;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] reg_reset_value(input int unsigned idx);
        case (idx)
            1:       return 32'd1;
            2:       return 32'd2;
            3, 10:   return DATA_BASE;
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] ram_reset_value(input int unsigned idx);
        case (idx)
            0:       return 32'd100;
            1:       return 32'd200;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/single_cycle_datapath_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// preset contents on asynchronous reset. $0 reads as zero and ignores writes.
module single_cycle_datapath_regfile
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= reg_reset_value(i);
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];

endmodule

// File: rtl/single_cycle_datapath.sv
// Single-cycle MIPS datapath (add/sub/and/or/slt/lw/sw/beq) with fixed boot ROM,
// preset data RAM and a debug write-back port.
module single_cycle_datapath
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ram_q [64];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;
    logic [31:0] rs_data, rt_data;
    logic [31:0] alu_b, alu_result, mem_rdata, pc_plus4;
    logic [5:0]  ram_idx;
    ctrl_t       ctrl;

    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    return 32'h0022_1820;
            6'd1:    return 32'h0022_1822;
            6'd2:    return 32'h0022_1824;
            6'd3:    return 32'h0022_1825;
            6'd4:    return 32'h0022_182A;
            6'd5:    return 32'h0041_182A;
            6'd6:    return 32'h1140_FFF9;
            6'd7:    return 32'h8D43_0000;
            6'd8:    return 32'h8D43_0004;
            6'd9:    return 32'hAD43_0008;
            6'd10:   return 32'h1000_FFF5;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // RESET_PC has zero low bits, so (pc - RESET_PC) >> 2 mod 64 is just pc[7:2].
    assign instr   = rom_word(pc_q[7:2]);
    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = sext16(instr[15:0]);

    always_comb begin
        ctrl = '{reg_write: 1'b0, reg_dst_rd: 1'b0, alu_src_imm: 1'b0, mem_write: 1'b0,
                 mem_to_reg: 1'b0, branch: 1'b0, alu_op: AluAdd};
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst_rd = 1'b1;
                ctrl.reg_write  = 1'b1;
                case (funct)
                    F_ADD:   ctrl.alu_op = AluAdd;
                    F_SUB:   ctrl.alu_op = AluSub;
                    F_AND:   ctrl.alu_op = AluAnd;
                    F_OR:    ctrl.alu_op = AluOr;
                    F_SLT:   ctrl.alu_op = AluSlt;
                    default: ctrl.reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.reg_write   = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
            end
            OP_BEQ:  ctrl.branch = 1'b1;
            default: ;
        endcase
    end

    single_cycle_datapath_regfile u_regfile (
        .clk_i     (clock),
        .rst_ni    (clear),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    assign alu_b = ctrl.alu_src_imm ? imm_ext : rt_data;

    always_comb begin
        alu_result = '0;
        case (ctrl.alu_op)
            AluAdd:  alu_result = rs_data + alu_b;
            AluSub:  alu_result = rs_data - alu_b;
            AluAnd:  alu_result = rs_data & alu_b;
            AluOr:   alu_result = rs_data | alu_b;
            AluSlt:  alu_result = {31'd0, $signed(rs_data) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end

    assign ram_idx   = alu_result[7:2];
    assign mem_rdata = ram_q[ram_idx];

    assign wb_en   = ctrl.reg_write;
    assign wb_addr = ctrl.reg_dst_rd ? rd : rt;
    assign wb_data = ctrl.mem_to_reg ? mem_rdata : alu_result;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_d     = (ctrl.branch && (rs_data == rt_data)) ? pc_plus4 + (imm_ext << 2)
                                                             : pc_plus4;
    assign pc       = pc_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 64; i++) begin
                ram_q[i] <= ram_reset_value(i);
            end
        end else if (ctrl.mem_write) begin
            ram_q[ram_idx] <= rt_data;
        end
    end

endmodule

// File: tb/tb_single_cycle_datapath.sv
// Scoreboard bench: an ISA-level interpreter predicts each cycle's debug outputs,
// a monitor compares them against the datapath on the falling edge.
module tb_single_cycle_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] pc, instr, wb_data;
    logic        wb_en;
    logic [4:0]  wb_addr;

    single_cycle_datapath dut (
        .clock   (clock),
        .clear   (clear),
        .pc      (pc),
        .instr   (instr),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] r3;
        logic [31:0] m2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Architectural reference state
    logic [31:0] m_rom [64];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_pc;

    task automatic model_reset();
        m_pc = 32'h0040_0000;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_reg[1]  = 32'd1;
        m_reg[2]  = 32'd2;
        m_reg[3]  = 32'h1001_0000;
        m_reg[10] = 32'h1001_0000;
        for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
        m_mem[0] = 32'd100;
        m_mem[1] = 32'd200;
    endtask

    // Execute the instruction at m_pc; report the attempted register write.
    task automatic model_step(input bit commit, output logic en, output logic [4:0] dst,
                              output logic [31:0] val);
        logic [31:0] ins, a, b, simm, addr, npc;
        int unsigned op, fn, s, t, d;
        ins  = m_rom[((m_pc - 32'h0040_0000) / 4) % 64];
        op   = ins >> 26;
        s    = (ins >> 21) % 32;
        t    = (ins >> 16) % 32;
        d    = (ins >> 11) % 32;
        fn   = ins % 64;
        a    = m_reg[s];
        b    = m_reg[t];
        simm = 32'(signed'(16'(ins % 65536)));
        addr = a + simm;
        npc  = m_pc + 4;
        en   = 1'b0;
        dst  = 5'd0;
        val  = 32'd0;
        if (op == 0) begin
            dst = 5'(d);
            en  = 1'b1;
            case (fn)
                32:      val = a + b;
                34:      val = a - b;
                36:      val = a & b;
                37:      val = a | b;
                42:      val = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                default: en = 1'b0;
            endcase
        end else if (op == 35) begin
            en  = 1'b1;
            dst = 5'(t);
            val = m_mem[(addr / 4) % 64];
        end else if (op == 43) begin
            if (commit) m_mem[(addr / 4) % 64] = b;
        end else if (op == 4) begin
            if (a == b) npc = npc + simm * 4;
        end
        if (commit) begin
            if (en && dst != 0) m_reg[dst] = val;
            m_pc = npc;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        model_step(1'b0, e.wb_en, e.wb_addr, e.wb_data);
        e.pc    = m_pc;
        e.instr = m_rom[((m_pc - 32'h0040_0000) / 4) % 64];
        e.r3    = m_reg[3];
        e.m2    = m_mem[2];
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, consumed on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard at %0t: got empty queue, expected a record", $time);
            end else begin
                e = exp_q.pop_front();
                vectors++;
                check("pc", pc, e.pc);
                check("instr", instr, e.instr);
                check("wb_en", {31'd0, wb_en}, {31'd0, e.wb_en});
                if (e.wb_en) begin
                    check("wb_addr", {27'd0, wb_addr}, {27'd0, e.wb_addr});
                    check("wb_data", wb_data, e.wb_data);
                end
                check("reg3", dut.u_regfile.regs_q[3], e.r3);
                check("ram2", dut.ram_q[2], e.m2);
            end
        end
    end

    initial begin
        logic        en;
        logic [4:0]  dst;
        logic [31:0] val;
        logic        nclear;
        for (int i = 0; i < 64; i++) m_rom[i] = 32'd0;
        m_rom[0] = 32'h0022_1820;  m_rom[1] = 32'h0022_1822;
        m_rom[2] = 32'h0022_1824;  m_rom[3] = 32'h0022_1825;
        m_rom[4] = 32'h0022_182A;  m_rom[5] = 32'h0041_182A;
        m_rom[6] = 32'h1140_FFF9;  m_rom[7] = 32'h8D43_0000;
        m_rom[8] = 32'h8D43_0004;  m_rom[9] = 32'hAD43_0008;
        m_rom[10] = 32'h1000_FFF5;
        clear = 1'b0;
        model_reset();
        for (int step = 0; step < 360; step++) begin
            @(posedge clock);
            #1;
            if (clear) model_step(1'b1, en, dst, val);
            // Two full passes, then a reset right after the second sw, then random pulses.
            if (step < 2) nclear = 1'b0;
            else if (step < 23) nclear = 1'b1;
            else if (step < 25) nclear = 1'b0;
            else if (step < 40) nclear = 1'b1;
            else if (clear) nclear = ($urandom_range(0, 19) != 0);
            else nclear = ($urandom_range(0, 1) != 0);
            if (!nclear) model_reset();
            clear = nclear;
            push_expected();
        end
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d records left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
